counter: RTL and testbench



---
 rtl/counter_pkg.sv | 17 +
 rtl/counter.sv | 53 +++++
 tb/tb_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the counter block: the default width and the
//   encoding of the count-direction input.
// -----------------------------------------------------------------------------
package counter_pkg;

  // Default counter width. The legal range is 1 to 32 bits.
  localparam int CW_DEFAULT = 8;

  // Encoding of the dir input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/counter.sv
// -----------------------------------------------------------------------------
// counter
//   Free-running binary up/down counter with a registered output. It steps on
//   every rising clock edge outside reset. Arithmetic is done at exactly cw
//   bits, so overflow and underflow wrap silently.
//
// Parameters
//   cw      counter width in bits (1..32)
//
// Ports
//   clk     system clock; all state updates happen on its rising edge
//   resetn  synchronous active-low reset; clears c_out and overrides dir
//   dir     1 = count up (+1), 0 = count down (-1)
//   c_out   current count, driven directly from the state register
// -----------------------------------------------------------------------------
module counter
  import counter_pkg::*;
#(
  parameter int cw = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          dir,
  output logic [cw-1:0] c_out
);

  localparam logic [cw-1:0] ZERO = {cw{1'b0}};
  localparam logic [cw-1:0] STEP = cw'(1);

  logic [cw-1:0] c_next;

  // Next-state mux. The sum is held at cw bits, which discards the carry
  // and borrow and gives modulo-2^cw wrap-around.
  always_comb begin
    c_next = c_out - STEP;
    if (dir == DIR_UP) begin
      c_next = c_out + STEP;
    end
  end

  // Reset is sampled on the clock edge only; there is no asynchronous path,
  // and c_out is undefined until the first edge that sees resetn low.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of c_out, avoiding simulation races.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      c_out <= ZERO;
    end else begin
      c_out <= c_next;
    end
  end

endmodule : counter

// File: tb/tb_counter.sv
// -----------------------------------------------------------------------------
// tb_counter
//   Self-checking bench for counter. Two instances run side by side on one
//   clock: cw = 8 (main) and cw = 4 (narrow-width wrap). A reference model
//   written as plain modulo arithmetic predicts each instance's value after
//   every edge; directed steps follow the block's test plan, then a
//   randomized phase mixes direction changes and occasional resets.
// -----------------------------------------------------------------------------
module tb_counter;

  logic       clk;
  logic       resetn8;
  logic       dir8;
  logic [7:0] c_out8;
  logic       resetn4;
  logic       dir4;
  logic [3:0] c_out4;

  int tests;
  int fails;

  // Reference model state: counts as plain integers in [0, 2^cw).
  int m8;
  int m4;

  counter #(.cw(8)) dut8 (
    .clk    (clk),
    .resetn (resetn8),
    .dir    (dir8),
    .c_out  (c_out8)
  );

  counter #(.cw(4)) dut4 (
    .clk    (clk),
    .resetn (resetn4),
    .dir    (dir4),
    .c_out  (c_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Model of one clock edge for a counter of the given modulus.
  function automatic int model_next(input int cur, input logic rst_n,
                                    input logic up, input int modulus);
    if (!rst_n) return 0;
    if (up) return (cur + 1) % modulus;
    return (cur + modulus - 1) % modulus;
  endfunction

  // Drive inputs on the falling edge, let one rising edge pass, then sample
  // 1 ns later and compare both instances with the model.
  task automatic step(input logic r8, input logic d8,
                      input logic r4, input logic d4);
    @(negedge clk);
    resetn8 = r8;
    dir8    = d8;
    resetn4 = r4;
    dir4    = d4;
    @(posedge clk);
    #1;
    m8 = model_next(m8, r8, d8, 256);
    m4 = model_next(m4, r4, d4, 16);
    check("model_cw8", 32'(c_out8), 32'(m8));
    check("model_cw4", 32'(c_out4), 32'(m4));
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    m8      = 0;
    m4      = 0;
    resetn8 = 1'b0;
    dir8    = 1'b0;
    resetn4 = 1'b0;
    dir4    = 1'b0;

    // Reset held for 7 edges with dir = 0: output stays zero.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_hold", 32'(c_out8), 32'h00);
    end

    // Release with dir = 0: immediate underflow, then keep counting down.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("down_first", 32'(c_out8), 32'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("down_second", 32'(c_out8), 32'hFE);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("down_third", 32'(c_out8), 32'hFD);
    for (int i = 3; i < 400; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("down_400", 32'(c_out8), 32'h70);

    // Up 400 edges from 0x70: passes 0xFF->0x00 twice and lands on 0x00.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("up_first", 32'(c_out8), 32'h71);
    for (int i = 1; i < 400; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("up_400", 32'(c_out8), 32'h00);

    // Reach 0x10, then alternate direction every edge starting with up.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("at_0x10", 32'(c_out8), 32'h10);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("toggle_1", 32'(c_out8), 32'h11);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("toggle_2", 32'(c_out8), 32'h10);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("toggle_3", 32'(c_out8), 32'h11);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("toggle_4", 32'(c_out8), 32'h10);

    // Reach 0x5A, reset for one edge, release counting up.
    for (int i = 0; i < 'h4A; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("at_0x5A", 32'(c_out8), 32'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("mid_reset", 32'(c_out8), 32'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_reset_up", 32'(c_out8), 32'h01);

    // cw = 4: reset is still held on that instance; count up 20 edges.
    check("cw4_reset", 32'(c_out4), 32'h0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("cw4_max", 32'(c_out4), 32'hF);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("cw4_wrap", 32'(c_out4), 32'h0);
    for (int i = 16; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check("cw4_20_up", 32'(c_out4), 32'h4);

    // Randomized phase: random direction, occasional one-edge resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(15) != 0), 1'($urandom),
           ($urandom_range(15) != 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_counter
